clk_period_meter: RTL

Measures a slow clock-like signal, such as the divided output of the team's clock divider, against the system clock. It reports the signal's period and its high time as counts of i_CLK cycles. It sits downstream of the divider as its receiving end. It gives the team a self-check that the divided clock has the intended ratio and duty cycle. Results appear as a one-cycle valid strobe with registered counts. Missing or stalled edges are flagged by a timeout.

---
 rtl/clk_period_meter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow signal
// in i_CLK cycles, with timeout and lock indication.
//   i_CLK     system clock, rising edge
//   i_RST     synchronous active-high reset
//   i_SIG     measured signal, may be asynchronous
//   o_VALID   one-cycle strobe, o_PERIOD/o_HIGH updated with it
//   o_PERIOD  cycles between the last two rising edges of i_SIG
//   o_HIGH    cycles i_SIG was high within that period
//   o_TIMEOUT one-cycle strobe, period counter saturated
//   o_LOCKED  high from first o_VALID until timeout or reset
module clk_period_meter #(
  parameter int WIDTH = 16
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_SIG,
  output logic             o_VALID,
  output logic [WIDTH-1:0] o_PERIOD,
  output logic [WIDTH-1:0] o_HIGH,
  output logic             o_TIMEOUT,
  output logic             o_LOCKED
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_e;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             s1_q, s2_q, prev_q;
  logic [1:0]       warm_q;
  logic [1:0]       warm_d;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;
  logic             lock_q, lock_d;
  logic             rise;

  assign rise = s2_q & ~prev_q;

  // s2 only holds a real sample of i_SIG two cycles after reset;
  // before that its reset value must not be read as "low".
  assign warm_d = {warm_q[0], 1'b1};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    tmo_d    = 1'b0;
    lock_d   = lock_q;
    unique case (state_q)
      IDLE: begin
        if (warm_q[1] && !s2_q) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (rise) begin
          cnt_d   = ONE;
          hi_d    = ONE;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d = cnt_q;
          high_d   = hi_q;
          valid_d  = 1'b1;
          lock_d   = 1'b1;
          cnt_d    = ONE;
          hi_d     = ONE;
        end else if (cnt_q == CNT_MAX) begin
          tmo_d   = 1'b1;
          lock_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
          hi_d  = hi_q + {{(WIDTH-1){1'b0}}, s2_q};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      prev_q   <= 1'b0;
      warm_q   <= 2'b00;
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
      lock_q   <= 1'b0;
    end else begin
      s1_q     <= i_SIG;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      warm_q   <= warm_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
      lock_q   <= lock_d;
    end
  end

  assign o_VALID   = valid_q;
  assign o_PERIOD  = period_q;
  assign o_HIGH    = high_q;
  assign o_TIMEOUT = tmo_q;
  assign o_LOCKED  = lock_q;

endmodule
